gpu_reset_sequencer: RTL and testbench
======================================

// Module: gpu_reset_sequencer
// PURPOSE
// - Downstream of the per-domain reset synchronisation; one instance per clock domain.
// - Takes the raw reset condition (~ext_rst_n | ~pll_locked) and releases subsystem resets in a fixed order.
// - Release order: memory (SDRAM controller) -> core (rasteriser/pipeline) -> io (SPI host interface).
// - Supervises SDRAM init with a timeout and retry; supports a software-requested re-sequence.
// PARAMETERS
// - SYNC_STAGES    2      flops in the deassertion synchroniser (>=2)
// - HOLD_CYCLES    16     cycles all resets stay held after synchronised deassertion (>=1)
// - STAGE_GAP      4      idle cycles between successive releases (>=0)
// - INIT_TIMEOUT   65535  max MEM_WAIT cycles for mem_init_done (>=1)
// - MAX_RETRIES    3      memory init attempts before FAULT (1..7)
// PORTS
// - clk               in   1  domain clock
// - rst_condition     in   1  asynchronous, active-high reset
// - soft_rst_req      in   1  sync pulse from register file; restart sequence
// - mem_init_done     in   1  SDRAM controller init complete (level)
// - mem_rst_n         out  1  memory subsystem reset, active-low
// - core_rst_n        out  1  core subsystem reset, active-low
// - io_rst_n          out  1  io subsystem reset, active-low
// - seq_done          out  1  all resets released
// - init_timeout_err  out  1  sticky: retries exhausted
// - retry_count       out  3  failed init attempts in current sequence
// BEHAVIOUR
// - Reset: rst_condition asynchronous, active-high; clock clk.
// - Assert: all outputs 0 immediately (async), FSM=HOLD, counters 0.
// - Deassert: SYNC_STAGES-flop chain (async set-low, sync shift-in 1); FSM advances only when chain output = 1.
// - States: HOLD -> MEM_WAIT -> GAP_CORE -> GAP_IO -> RUN; FAULT.
// - HOLD: count HOLD_CYCLES; next edge mem_rst_n<=1, enter MEM_WAIT.
// - mem_rst_n rises exactly SYNC_STAGES+HOLD_CYCLES+1 edges after rst_condition falls (defaults: 19).
// - MEM_WAIT: mem_init_done sampled only here.
//   - Sampled high: enter GAP_CORE.
//   - Else timeout counter +1; on reaching INIT_TIMEOUT:
//     - retry_count+1, mem_rst_n<=0, back to HOLD.
//     - If new retry_count == MAX_RETRIES: enter FAULT instead.
//   - mem_init_done high on the timeout cycle: done wins.
// - GAP_CORE: STAGE_GAP cycles, then core_rst_n<=1.
//   - core_rst_n rises STAGE_GAP+1 edges after mem_init_done sampled.
// - GAP_IO: STAGE_GAP cycles, then io_rst_n<=1 and seq_done<=1 on the same edge; enter RUN.
// - RUN: hold; mem_init_done changes ignored.
// - FAULT: mem/core/io_rst_n=0, seq_done=0, init_timeout_err=1 (sticky).
// - soft_rst_req, any state incl. FAULT, registered:
//   - next edge: all *_rst_n=0, seq_done=0, init_timeout_err=0, retry_count=0, enter HOLD.
//   - Sync chain not re-run.
//   - Takes priority over any same-cycle transition.
// - rst_condition mid-sequence: immediate async clear to reset values; full sequence restarts on deassert.
// - Releases are monotonic within a sequence:
//   - core never 1 while mem is 0; io never 1 while core is 0.
//   - Any return to HOLD drops all three together.
// - Counters sized $clog2(max+1); no wrap (saturating compare).
// STRUCTURE
// - Package gpu_reset_pkg: rst_seq_state_e enum, RST_SEQ_* default constants.
// - Sub-module rst_release_sync: parameterised SYNC_STAGES async-assert/sync-deassert chain; FSM, counters, outputs here.
// TESTING (HOLD_CYCLES=16, STAGE_GAP=4, INIT_TIMEOUT=100, MAX_RETRIES=3, SYNC_STAGES=2)
// - Power-up: rst_condition 1->0 at edge 0; mem_init_done=1 from edge 30.
//   - Expect mem_rst_n=1 @19; core_rst_n=1 @35; io_rst_n=1 and seq_done=1 @40.
// - Timeout retry: mem_init_done low for the first 100 MEM_WAIT cycles.
//   - Expect mem_rst_n drop, retry_count=1, mem_rst_n re-rise 17 edges later.
//   - Assert mem_init_done -> normal completion, retry_count stays 1.
// - Fault: mem_init_done never asserted.
//   - Expect 3 attempts, then FAULT: init_timeout_err=1, all resets 0.
//   - Pulse soft_rst_req -> err=0, retry_count=0, sequence restarts.
// - Mid-sequence reset: rst_condition pulse (1 cycle, between edges) during GAP_CORE.
//   - Expect all outputs 0 same cycle (async); mem_rst_n re-rise 19 edges after it falls.
// - Soft reset in RUN: soft_rst_req=1 for one cycle.
//   - Expect all resets 0 and seq_done=0 next edge; mem_rst_n=1 17 edges later (no sync delay).
// - Races: mem_init_done rises on the 100th MEM_WAIT cycle -> GAP_CORE, no retry.
//   - soft_rst_req on the GAP_IO exit cycle -> io_rst_n stays 0.

Source files
------------

// File: rtl/gpu_reset_pkg.sv
// Shared constants and state encoding for the GPU reset sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package gpu_reset_pkg;

    // Default sequencing parameters.
    localparam int RST_SEQ_SYNC_STAGES  = 2;
    localparam int RST_SEQ_HOLD_CYCLES  = 16;
    localparam int RST_SEQ_STAGE_GAP    = 4;
    localparam int RST_SEQ_INIT_TIMEOUT = 65535;
    localparam int RST_SEQ_MAX_RETRIES  = 3;

    // State codes kept as plain constants so existing code that decodes the
    // 3-bit state value keeps working; the enum names the same codes.
    localparam logic [2:0] ST_HOLD     = 3'd0;
    localparam logic [2:0] ST_MEM_WAIT = 3'd1;
    localparam logic [2:0] ST_GAP_CORE = 3'd2;
    localparam logic [2:0] ST_GAP_IO   = 3'd3;
    localparam logic [2:0] ST_RUN      = 3'd4;
    localparam logic [2:0] ST_FAULT    = 3'd5;

    typedef enum logic [2:0] {
        RST_SEQ_HOLD     = ST_HOLD,
        RST_SEQ_MEM_WAIT = ST_MEM_WAIT,
        RST_SEQ_GAP_CORE = ST_GAP_CORE,
        RST_SEQ_GAP_IO   = ST_GAP_IO,
        RST_SEQ_RUN      = ST_RUN,
        RST_SEQ_FAULT    = ST_FAULT
    } rst_seq_state_e;

endpackage

// File: rtl/gpu_reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and its surroundings.
// Latency: n/a (wires only).
// Backpressure: none; all signals are levels or single-cycle pulses.
// master: the sequencer (drives resets/status, receives requests).
// slave : register file / SDRAM controller side.
interface gpu_reset_sequencer_if;
    logic       soft_rst_req;      // one-cycle pulse: restart the sequence
    logic       mem_init_done;     // SDRAM controller init complete (level)
    logic       mem_rst_n;         // memory subsystem reset, active-low
    logic       core_rst_n;        // core subsystem reset, active-low
    logic       io_rst_n;          // io subsystem reset, active-low
    logic       seq_done;          // all resets released
    logic       init_timeout_err;  // sticky: memory init retries exhausted
    logic [2:0] retry_count;       // failed init attempts this sequence

    modport master (
        input  soft_rst_req, mem_init_done,
        output mem_rst_n, core_rst_n, io_rst_n, seq_done,
               init_timeout_err, retry_count
    );

    modport slave (
        output soft_rst_req, mem_init_done,
        input  mem_rst_n, core_rst_n, io_rst_n, seq_done,
               init_timeout_err, retry_count
    );
endinterface

// File: rtl/gpu_reset_sequencer_sync.sv
// Reset release synchroniser: async assert, STAGES-flop synchronous deassert.
// Latency: sync_ok rises STAGES edges after rst_condition falls; falls immediately.
// Backpressure: none.
// Ports: clk, rst_condition (async, active-high) in; sync_ok out.
module rst_release_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_condition,
    output logic sync_ok
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst_condition) begin
        if (rst_condition) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = chain[STAGES-1];

endmodule

// File: rtl/gpu_reset_sequencer.sv
// Releases memory -> core -> io resets in order, supervising SDRAM init with timeout/retry.
// Latency: mem_rst_n rises SYNC_STAGES+HOLD_CYCLES+1 edges after rst_condition falls.
// Backpressure: none; soft_rst_req restarts the sequence on the next edge from any state.
// Ports: clk, rst_condition (async, active-high); rs = master side of gpu_reset_sequencer_if.
module gpu_reset_sequencer
    import gpu_reset_pkg::*;
#(
    parameter int SYNC_STAGES  = RST_SEQ_SYNC_STAGES,
    parameter int HOLD_CYCLES  = RST_SEQ_HOLD_CYCLES,
    parameter int STAGE_GAP    = RST_SEQ_STAGE_GAP,
    parameter int INIT_TIMEOUT = RST_SEQ_INIT_TIMEOUT,
    parameter int MAX_RETRIES  = RST_SEQ_MAX_RETRIES
) (
    input  logic                  clk,
    input  logic                  rst_condition,
    gpu_reset_sequencer_if.master rs
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int GAP_W  = (STAGE_GAP > 0) ? $clog2(STAGE_GAP + 1) : 1;
    localparam int TMO_W  = $clog2(INIT_TIMEOUT + 1);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(STAGE_GAP);
    // The timeout fires on the edge where the count would reach INIT_TIMEOUT.
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(INIT_TIMEOUT - 1);
    localparam logic [2:0]        RETRY_MAX = 3'(MAX_RETRIES);

    logic              sync_ok;
    logic [2:0]        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [2:0]        retry_q;
    logic [2:0]        retry_nxt;
    logic              mem_q, core_q, io_q, done_q, err_q;

    rst_release_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk           (clk),
        .rst_condition (rst_condition),
        .sync_ok       (sync_ok)
    );

    assign retry_nxt = retry_q + 3'd1;

    // Outputs are flops so the reset lines are glitch-free and clear
    // asynchronously together with the state.
    always_ff @(posedge clk or posedge rst_condition) begin
        if (rst_condition) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            tmo_cnt  <= '0;
            retry_q  <= '0;
            mem_q    <= 1'b0;
            core_q   <= 1'b0;
            io_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (rs.soft_rst_req) begin
            // Restart from HOLD without re-running the synchroniser; wins over
            // whatever transition the FSM would otherwise make this edge.
            state    <= ST_HOLD;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            tmo_cnt  <= '0;
            retry_q  <= '0;
            mem_q    <= 1'b0;
            core_q   <= 1'b0;
            io_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (sync_ok) begin
            case (state)
                ST_HOLD: begin
                    if (hold_cnt == HOLD_MAX) begin
                        hold_cnt <= '0;
                        tmo_cnt  <= '0;
                        mem_q    <= 1'b1;
                        state    <= ST_MEM_WAIT;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    // A done seen on the timeout edge still counts as success.
                    if (rs.mem_init_done) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP_CORE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt  <= '0;
                        hold_cnt <= '0;
                        mem_q    <= 1'b0;
                        retry_q  <= retry_nxt;
                        if (retry_nxt == RETRY_MAX) begin
                            err_q <= 1'b1;
                            state <= ST_FAULT;
                        end else begin
                            state <= ST_HOLD;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_GAP_CORE: begin
                    if (gap_cnt == GAP_MAX) begin
                        gap_cnt <= '0;
                        core_q  <= 1'b1;
                        state   <= ST_GAP_IO;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_GAP_IO: begin
                    if (gap_cnt == GAP_MAX) begin
                        gap_cnt <= '0;
                        io_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state   <= ST_RUN;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_RUN: begin
                    // Hold released; mem_init_done is no longer observed.
                end
                ST_FAULT: begin
                    mem_q  <= 1'b0;
                    core_q <= 1'b0;
                    io_q   <= 1'b0;
                    done_q <= 1'b0;
                    err_q  <= 1'b1;
                end
                default: begin
                    state    <= ST_HOLD;
                    hold_cnt <= '0;
                    mem_q    <= 1'b0;
                    core_q   <= 1'b0;
                    io_q     <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rs.mem_rst_n        = mem_q;
    assign rs.core_rst_n       = core_q;
    assign rs.io_rst_n         = io_q;
    assign rs.seq_done         = done_q;
    assign rs.init_timeout_err = err_q;
    assign rs.retry_count      = retry_q;

endmodule

// File: tb/tb_gpu_reset_sequencer.sv
// Directed bench for gpu_reset_sequencer (HOLD=16, GAP=4, TIMEOUT=100, RETRIES=3, SYNC=2).
// Edge numbering: edge 0 is the clock edge just before rst_condition falls.
// Outputs are sampled 1 time unit after each rising edge.
module tb_gpu_reset_sequencer;

    logic clk = 1'b0;
    logic rst_condition;

    gpu_reset_sequencer_if rif ();

    gpu_reset_sequencer #(
        .SYNC_STAGES  (2),
        .HOLD_CYCLES  (16),
        .STAGE_GAP    (4),
        .INIT_TIMEOUT (100),
        .MAX_RETRIES  (3)
    ) dut (
        .clk           (clk),
        .rst_condition (rst_condition),
        .rs            (rif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic chk_rel(input string tag, input logic m, input logic c,
                           input logic i, input logic d);
        chk({tag, "_mem"},  32'(rif.mem_rst_n),  32'(m));
        chk({tag, "_core"}, 32'(rif.core_rst_n), 32'(c));
        chk({tag, "_io"},   32'(rif.io_rst_n),   32'(i));
        chk({tag, "_done"}, 32'(rif.seq_done),   32'(d));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    // Hold reset a few cycles, then release it just after an edge (edge 0).
    task automatic start_seq();
        rst_condition        = 1'b1;
        rif.soft_rst_req     = 1'b0;
        rif.mem_init_done    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_condition = 1'b0;
        edge_n        = 0;
    endtask

    initial begin
        rst_condition     = 1'b1;
        rif.soft_rst_req  = 1'b0;
        rif.mem_init_done = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_rel("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_err",   32'(rif.init_timeout_err), 32'd0);
        chk("rst_retry", 32'(rif.retry_count),      32'd0);

        // Power-up: done from edge 30 -> mem@19, core@35, io/done@40
        start_seq();
        for (int e = 1; e <= 45; e++) begin
            tick();
            chk_rel("pu", e >= 19, e >= 35, e >= 40, e >= 40);
            if (e == 29) rif.mem_init_done = 1'b1;
        end
        chk("pu_retry", 32'(rif.retry_count), 32'd0);

        // Timeout retry: timeout at 119, re-release at 136, done sampled at 137
        start_seq();
        run_to(118);
        chk_rel("tr118", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_rel("tr119", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tr_retry1", 32'(rif.retry_count), 32'd1);
        run_to(135);
        chk("tr135_mem", 32'(rif.mem_rst_n), 32'd0);
        tick();
        chk("tr136_mem", 32'(rif.mem_rst_n), 32'd1);
        rif.mem_init_done = 1'b1;
        run_to(141);
        chk("tr141_core", 32'(rif.core_rst_n), 32'd0);
        tick();
        chk("tr142_core", 32'(rif.core_rst_n), 32'd1);
        run_to(146);
        chk("tr146_done", 32'(rif.seq_done), 32'd0);
        tick();
        chk_rel("tr147", 1'b1, 1'b1, 1'b1, 1'b1);
        chk("tr_retry_end", 32'(rif.retry_count), 32'd1);

        // Fault: timeouts at 119, 236, 353 -> FAULT
        start_seq();
        run_to(236);
        chk("f236_retry", 32'(rif.retry_count), 32'd2);
        chk("f236_mem",   32'(rif.mem_rst_n),   32'd0);
        run_to(352);
        chk("f352_mem", 32'(rif.mem_rst_n),        32'd1);
        chk("f352_err", 32'(rif.init_timeout_err), 32'd0);
        tick();
        chk("f353_err",   32'(rif.init_timeout_err), 32'd1);
        chk("f353_retry", 32'(rif.retry_count),      32'd3);
        chk_rel("f353", 1'b0, 1'b0, 1'b0, 1'b0);
        run_to(380);
        chk_rel("f380", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("f380_err", 32'(rif.init_timeout_err), 32'd1);
        rif.soft_rst_req = 1'b1;
        tick();
        rif.soft_rst_req = 1'b0;
        chk("fs_err",   32'(rif.init_timeout_err), 32'd0);
        chk("fs_retry", 32'(rif.retry_count),      32'd0);
        run_to(397);
        chk("fs397_mem", 32'(rif.mem_rst_n), 32'd0);
        tick();
        chk("fs398_mem", 32'(rif.mem_rst_n), 32'd1);
        rif.mem_init_done = 1'b1;
        run_to(409);
        chk_rel("fs409", 1'b1, 1'b1, 1'b1, 1'b1);

        // Mid-sequence async reset during GAP_CORE (done sampled at 20)
        start_seq();
        rif.mem_init_done = 1'b1;
        run_to(22);
        chk_rel("mr22", 1'b1, 1'b0, 1'b0, 1'b0);
        rst_condition = 1'b1;
        #1;
        chk_rel("mr_async", 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        rst_condition = 1'b0;
        run_to(40);
        chk("mr40_mem", 32'(rif.mem_rst_n), 32'd0);
        tick();
        chk("mr41_mem", 32'(rif.mem_rst_n), 32'd1);
        run_to(47);
        chk("mr47_core", 32'(rif.core_rst_n), 32'd1);
        run_to(52);
        chk_rel("mr52", 1'b1, 1'b1, 1'b1, 1'b1);

        // Soft reset in RUN: drop at 61, mem back at 78, done at 89
        run_to(60);
        rif.soft_rst_req = 1'b1;
        tick();
        rif.soft_rst_req = 1'b0;
        chk_rel("sr61", 1'b0, 1'b0, 1'b0, 1'b0);
        run_to(77);
        chk("sr77_mem", 32'(rif.mem_rst_n), 32'd0);
        tick();
        chk("sr78_mem", 32'(rif.mem_rst_n), 32'd1);
        run_to(88);
        chk_rel("sr88", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_rel("sr89", 1'b1, 1'b1, 1'b1, 1'b1);

        // Race: done arrives on the 100th MEM_WAIT cycle (edge 119) -> no retry
        start_seq();
        run_to(118);
        rif.mem_init_done = 1'b1;
        tick();
        chk("rc119_mem",   32'(rif.mem_rst_n),   32'd1);
        chk("rc119_retry", 32'(rif.retry_count), 32'd0);
        run_to(124);
        chk("rc124_core", 32'(rif.core_rst_n), 32'd1);
        run_to(129);
        chk_rel("rc129", 1'b1, 1'b1, 1'b1, 1'b1);
        rif.mem_init_done = 1'b0;
        run_to(139);
        chk_rel("rc_run_hold", 1'b1, 1'b1, 1'b1, 1'b1);

        // Race: soft reset on the GAP_IO exit edge (30) -> io never rises
        start_seq();
        rif.mem_init_done = 1'b1;
        run_to(29);
        chk_rel("rs29", 1'b1, 1'b1, 1'b0, 1'b0);
        rif.soft_rst_req = 1'b1;
        tick();
        rif.soft_rst_req = 1'b0;
        chk_rel("rs30", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rs31_io", 32'(rif.io_rst_n), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
